systolic_pe_dualmode: RTL and testbench

//  Parametrised MAC processing element for the systolic array. Supports two modes:
//  - Output-stationary (OS): accumulates locally, then drains its result down a

---
 rtl/systolic_pkg.sv | 46 ++++
 rtl/pe_sat_adder.sv | 26 ++
 rtl/systolic_pe_dualmode.sv | 152 +++++++++++++++
 tb/tb_systolic_pe_dualmode.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and the width-generic saturating add used by the systolic PE.
// Widths up to SAT_MAX_W-1 bits are supported by sat_add.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OS_ACC,
        S_OS_DRAIN,
        S_WS
    } pe_state_t;

    localparam logic MODE_OS   = 1'b0;
    localparam logic MODE_WS   = 1'b1;
    localparam int   SAT_MAX_W = 64;

    // Operands arrive sign-extended to SAT_MAX_W; the sum is checked against the
    // w-bit signed range. Returns {overflow, result sign-extended to SAT_MAX_W}.
    function automatic logic [SAT_MAX_W:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w,
        input logic                        saturate
    );
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] sum;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        logic signed [SAT_MAX_W:0] res;
        logic                      ovf;
        one    = '0;
        one[0] = 1'b1;
        sum    = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
        hi     = (one <<< (w - 1)) - one;
        lo     = -(one <<< (w - 1));
        ovf    = (sum > hi) || (sum < lo);
        if (!ovf) begin
            res = sum;
        end else if (saturate) begin
            res = (sum > hi) ? hi : lo;
        end else begin
            res = (sum <<< (SAT_MAX_W + 1 - w)) >>> (SAT_MAX_W + 1 - w);
        end
        return {ovf, res[SAT_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/pe_sat_adder.sv
// Signed ACC_WIDTH adder with clamp-or-wrap and overflow flag; purely combinational.
module pe_sat_adder
    import systolic_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int SATURATE  = 1
) (
    input  logic [ACC_WIDTH-1:0] a_i,
    input  logic [ACC_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 ovf_o
);

    logic [SAT_MAX_W:0] res_d;
    logic               unused_hi_bits;

    always_comb begin
        res_d = sat_add(SAT_MAX_W'($signed(a_i)), SAT_MAX_W'($signed(b_i)),
                        ACC_WIDTH, (SATURATE != 0));
    end

    assign sum_o          = res_d[ACC_WIDTH-1:0];
    assign ovf_o          = res_d[SAT_MAX_W];
    assign unused_hi_bits = ^res_d[SAT_MAX_W-1:ACC_WIDTH];

endmodule

// File: rtl/systolic_pe_dualmode.sv
// Dual-mode (output-/weight-stationary) systolic MAC cell; all outputs registered,
// one cycle latency, no backpressure (neighbours are lock-step).
module systolic_pe_dualmode
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_i,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic                  psum_valid_in,
    input  logic                  acc_clear,
    input  logic                  w_load,
    input  logic                  drain_i,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  valid_out,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  psum_valid_out,
    output logic                  sat_flag
);

    localparam int PW = 2 * DATA_WIDTH;

    pe_state_t             state_q;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] weight_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic                  drain_first_q;
    logic [DATA_WIDTH-1:0] a_out_q;
    logic [DATA_WIDTH-1:0] b_out_q;
    logic                  valid_out_q;
    logic [ACC_WIDTH-1:0]  psum_out_q;
    logic                  psum_valid_out_q;
    logic                  sat_q;

    logic                  ws_path_d;
    logic [DATA_WIDTH-1:0] mul_b_d;
    logic signed [PW-1:0]  prod_d;
    logic [ACC_WIDTH-1:0]  prod_ext_d;
    logic [ACC_WIDTH-1:0]  add_a_d;
    logic [ACC_WIDTH-1:0]  sum_d;
    logic                  ovf_d;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic                  os_mac_d;
    logic                  ws_mac_d;
    logic                  sat_d;

    // One multiplier/adder pair serves both modes: WS adds to the passing psum,
    // OS adds to the local accumulator (or to zero when a new tile starts).
    assign ws_path_d  = (state_q == S_WS) && (mode_q == MODE_WS);
    assign mul_b_d    = ws_path_d ? weight_q : b_in;
    assign prod_d     = PW'($signed(a_in)) * PW'($signed(mul_b_d));
    assign prod_ext_d = ACC_WIDTH'(prod_d);
    assign add_a_d    = ws_path_d ? psum_in : (acc_clear ? '0 : acc_q);

    pe_sat_adder #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_sat_adder (
        .a_i   (add_a_d),
        .b_i   (prod_ext_d),
        .sum_o (sum_d),
        .ovf_o (ovf_d)
    );

    assign acc_d    = valid_in ? sum_d : '0;
    assign os_mac_d = valid_in && (((state_q == S_IDLE) && (mode_i == MODE_OS)) ||
                                   ((state_q == S_OS_ACC) && !drain_i));
    assign ws_mac_d = ws_path_d && valid_in && psum_valid_in;
    assign sat_d    = (sat_q && !acc_clear) || (ovf_d && (os_mac_d || ws_mac_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            mode_q           <= MODE_OS;
            weight_q         <= '0;
            acc_q            <= '0;
            drain_first_q    <= 1'b0;
            a_out_q          <= '0;
            b_out_q          <= '0;
            valid_out_q      <= 1'b0;
            psum_out_q       <= '0;
            psum_valid_out_q <= 1'b0;
            sat_q            <= 1'b0;
        end else begin
            a_out_q     <= a_in;
            b_out_q     <= b_in;
            valid_out_q <= valid_in;
            sat_q       <= sat_d;
            case (state_q)
                S_IDLE: begin
                    mode_q           <= mode_i;
                    psum_valid_out_q <= 1'b0;
                    if (mode_i == MODE_WS) begin
                        state_q <= S_WS;
                    end else if (valid_in || acc_clear) begin
                        state_q <= S_OS_ACC;
                        acc_q   <= acc_d;
                    end
                end
                S_OS_ACC: begin
                    psum_valid_out_q <= 1'b0;
                    if (drain_i) begin
                        state_q       <= S_OS_DRAIN;
                        drain_first_q <= 1'b1;
                    end else if (valid_in || acc_clear) begin
                        acc_q <= acc_d;
                    end
                end
                S_OS_DRAIN: begin
                    if (!drain_i) begin
                        state_q          <= S_IDLE;
                        psum_valid_out_q <= 1'b0;
                    end else if (drain_first_q) begin
                        psum_out_q       <= acc_q;
                        psum_valid_out_q <= 1'b1;
                        drain_first_q    <= 1'b0;
                    end else begin
                        psum_out_q       <= psum_in;
                        psum_valid_out_q <= psum_valid_in;
                    end
                end
                S_WS: begin
                    if (w_load) begin
                        weight_q <= b_in;
                    end
                    psum_out_q       <= sum_d;
                    psum_valid_out_q <= valid_in && psum_valid_in;
                    if (mode_i == MODE_OS) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_out          = a_out_q;
    assign b_out          = b_out_q;
    assign valid_out      = valid_out_q;
    assign psum_out       = psum_out_q;
    assign psum_valid_out = psum_valid_out_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_systolic_pe_dualmode.sv
// Directed bench: one 24-bit saturating PE plus 16-bit saturating and wrapping PEs
// driven with identical stimulus.
module tb_systolic_pe_dualmode;

    logic        clk = 1'b0;
    logic        rst, mode_i, valid_in, acc_clear, w_load, drain_i, psum_valid_in;
    logic [7:0]  a_in, b_in;
    logic [23:0] psum_in;

    logic [7:0]  a_out, b_out, s_a_out, s_b_out, w_a_out, w_b_out;
    logic        valid_out, s_valid_out, w_valid_out;
    logic [23:0] psum_out;
    logic [15:0] s_psum_out, w_psum_out;
    logic        psum_valid_out, s_psum_valid_out, w_psum_valid_out;
    logic        sat_flag, s_sat_flag, w_sat_flag;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    systolic_pe_dualmode #(.DATA_WIDTH(8), .ACC_WIDTH(24), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in), .acc_clear(acc_clear),
        .w_load(w_load), .drain_i(drain_i), .a_out(a_out), .b_out(b_out),
        .valid_out(valid_out), .psum_out(psum_out), .psum_valid_out(psum_valid_out),
        .sat_flag(sat_flag));

    systolic_pe_dualmode #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) u_sat16 (
        .clk(clk), .rst(rst), .mode_i(mode_i), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .psum_in(psum_in[15:0]), .psum_valid_in(psum_valid_in), .acc_clear(acc_clear),
        .w_load(w_load), .drain_i(drain_i), .a_out(s_a_out), .b_out(s_b_out),
        .valid_out(s_valid_out), .psum_out(s_psum_out), .psum_valid_out(s_psum_valid_out),
        .sat_flag(s_sat_flag));

    systolic_pe_dualmode #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) u_wrap16 (
        .clk(clk), .rst(rst), .mode_i(mode_i), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .psum_in(psum_in[15:0]), .psum_valid_in(psum_valid_in), .acc_clear(acc_clear),
        .w_load(w_load), .drain_i(drain_i), .a_out(w_a_out), .b_out(w_b_out),
        .valid_out(w_valid_out), .psum_out(w_psum_out), .psum_valid_out(w_psum_valid_out),
        .sat_flag(w_sat_flag));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Advance one clock and check the forwarding registers against what was driven.
    task automatic tick();
        logic [7:0] pa, pb;
        logic       pv;
        pa = rst ? 8'd0 : a_in;
        pb = rst ? 8'd0 : b_in;
        pv = rst ? 1'b0 : valid_in;
        @(posedge clk);
        #1;
        chk("a_out", 32'(a_out), 32'(pa));
        chk("b_out", 32'(b_out), 32'(pb));
        chk("valid_out", 32'(valid_out), 32'(pv));
        chk("s_a_out", 32'(s_a_out), 32'(pa));
        chk("w_valid_out", 32'(w_valid_out), 32'(pv));
    endtask

    task automatic mac(input int a, input int b, input logic clr);
        valid_in  = 1'b1;
        a_in      = 8'(a);
        b_in      = 8'(b);
        acc_clear = clr;
        tick();
        valid_in  = 1'b0;
        acc_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode_i = 1'b0; valid_in = 1'b0; acc_clear = 1'b0; w_load = 1'b0;
        drain_i = 1'b0; psum_valid_in = 1'b0; a_in = 8'h5A; b_in = 8'hA5; psum_in = 24'd0;
        tick();
        tick();
        chk("rst_psum_out", 32'(psum_out), 32'd0);
        chk("rst_psum_valid", 32'(psum_valid_out), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
        rst = 1'b0;

        // OS accumulate 3*4 - 2*5 + 7*7 = 51; mode_i toggling mid-tile is ignored
        mac(3, 4, 1'b1);
        mode_i = 1'b1;
        mac(-2, 5, 1'b0);
        mode_i = 1'b0;
        mac(7, 7, 1'b0);
        drain_i = 1'b1; psum_in = 24'd99; psum_valid_in = 1'b1;
        tick();
        chk("os_enter_drain_valid", 32'(psum_valid_out), 32'd0);
        tick();
        chk("os_drain1_psum", 32'($signed(psum_out)), 32'd51);
        chk("os_drain1_valid", 32'(psum_valid_out), 32'd1);
        chk("os_drain1_psum16", 32'($signed(s_psum_out)), 32'd51);
        tick();
        chk("os_drain2_psum", 32'($signed(psum_out)), 32'd99);
        chk("os_drain2_valid", 32'(psum_valid_out), 32'd1);
        drain_i = 1'b0; psum_valid_in = 1'b0;
        tick();
        chk("os_drain_exit_valid", 32'(psum_valid_out), 32'd0);

        // Clear+valid restarts from the product; drain cycle swallows its MAC
        mac(5, 8, 1'b1);
        mac(5, 6, 1'b1);
        drain_i = 1'b1;
        mac(1, 2, 1'b0);
        psum_in = 24'(-7); psum_valid_in = 1'b0;
        tick();
        chk("clr_valid_psum", 32'($signed(psum_out)), 32'd30);
        tick();
        chk("shift_psum", 32'($signed(psum_out)), -32'sd7);
        chk("shift_valid", 32'(psum_valid_out), 32'd0);
        drain_i = 1'b0;
        tick();
        // acc survives the return to idle and keeps accumulating without a clear
        mac(1, 1, 1'b0);
        drain_i = 1'b1;
        tick();
        tick();
        chk("acc_kept_psum", 32'($signed(psum_out)), 32'd31);
        drain_i = 1'b0;
        tick();

        // 127*127 = 16129; three of them overflow 16 bits but not 24
        mac(127, 127, 1'b1);
        mac(127, 127, 1'b0);
        chk("sat16_not_yet", 32'(s_sat_flag), 32'd0);
        mac(127, 127, 1'b0);
        chk("sat16_flag", 32'(s_sat_flag), 32'd1);
        chk("wrap16_flag", 32'(w_sat_flag), 32'd1);
        chk("sat24_flag", 32'(sat_flag), 32'd0);
        drain_i = 1'b1; psum_valid_in = 1'b1; psum_in = 24'd5;
        tick();
        tick();
        chk("acc24_psum", 32'($signed(psum_out)), 32'd48387);
        chk("sat16_psum", 32'($signed(s_psum_out)), 32'd32767);
        chk("wrap16_psum", 32'($signed(w_psum_out)), -32'sd17149);
        chk("sat16_valid", 32'(s_psum_valid_out), 32'd1);

        // Reset in drain cycle 2 overrides the still-held drain request
        rst = 1'b1; valid_in = 1'b1; a_in = 8'h33; b_in = 8'h44;
        tick();
        rst = 1'b0; valid_in = 1'b0; drain_i = 1'b0; psum_valid_in = 1'b0;
        chk("midrst_psum", 32'(psum_out), 32'd0);
        chk("midrst_valid", 32'(psum_valid_out), 32'd0);
        chk("midrst_sat16", 32'(s_sat_flag), 32'd0);
        chk("midrst_wrap16", 32'(w_sat_flag), 32'd0);
        chk("midrst_wrap_psum", 32'(w_psum_out), 32'd0);
        mac(2, 3, 1'b0);
        drain_i = 1'b1;
        tick();
        tick();
        chk("post_rst_acc", 32'($signed(psum_out)), 32'd6);
        drain_i = 1'b0;
        tick();

        // WS: load weight -3, then 100 + 10*(-3) = 70
        mode_i = 1'b1;
        tick();
        w_load = 1'b1; b_in = 8'(-3);
        tick();
        w_load = 1'b0; psum_in = 24'd100; psum_valid_in = 1'b1;
        mac(10, 0, 1'b0);
        chk("ws_psum", 32'($signed(psum_out)), 32'd70);
        chk("ws_valid", 32'(psum_valid_out), 32'd1);
        w_load = 1'b1; psum_in = 24'd0;
        mac(4, 2, 1'b0);
        w_load = 1'b0;
        chk("ws_old_weight", 32'($signed(psum_out)), -32'sd12);
        mac(1, 0, 1'b0);
        chk("ws_new_weight", 32'($signed(psum_out)), 32'd2);
        psum_valid_in = 1'b0;
        mac(1, 0, 1'b0);
        chk("ws_psum_invalid", 32'(psum_valid_out), 32'd0);
        psum_valid_in = 1'b1; psum_in = 24'd32767;
        mac(1, 0, 1'b0);
        chk("ws_psum24", 32'($signed(psum_out)), 32'd32769);
        chk("ws_sat16_psum", 32'($signed(s_psum_out)), 32'd32767);
        chk("ws_wrap16_psum", 32'($signed(w_psum_out)), -32'sd32767);
        chk("ws_sat16_flag", 32'(s_sat_flag), 32'd1);
        chk("ws_sat24_flag", 32'(sat_flag), 32'd0);
        mode_i = 1'b0; psum_valid_in = 1'b0;
        tick();
        tick();
        chk("ws_exit_valid", 32'(psum_valid_out), 32'd0);

        // Random operands through idle, accumulate and drain states
        for (int i = 0; i < 12; i++) begin
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            valid_in = 1'($urandom_range(0, 1));
            drain_i  = (i >= 6 && i < 10);
            tick();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
